// File: rtl/mult_div_unit_if.sv
// Bundle of the MDU request/response signals between the pipeline (master)
// and the multiply/divide unit (slave).
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        rd_sel;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  modport master (
    output start, md_op, A, B, rd_sel,
    input  busy, stall_req, HI, LO, md_out
  );

  modport slave (
    input  start, md_op, A, B, rd_sel,
    output busy, stall_req, HI, LO, md_out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Multiplies take 5 busy cycles and divides take 10. The result is computed
// from the latched operands and committed on the last RUN edge, so HI/LO keep
// their pre-operation values for the whole operation.
// Optional feature: define MULT_DIV_MADD_EN to enable MADD/MADDU
// ({HI,LO} += A*B); otherwise those opcodes are no-ops.
module mult_div_unit (
  input  logic           clk,
  input  logic           reset_n,
  mult_div_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [3:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;

  logic        signed_op_s;
  logic [63:0] prod_s;
  logic [63:0] div_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // 32x32 -> 64 product; operands are extended to 64 bits first so a single
  // unsigned multiplier yields the correct low 64 bits for both signednesses.
  function automatic logic [63:0] mul64(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {(sgn ? {32{a[31]}} : 32'h0000_0000), a};
    eb = {(sgn ? {32{b[31]}} : 32'h0000_0000), b};
    return ea * eb;
  endfunction

  // Two's-complement negate of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Divide on magnitudes and restore signs: quotient truncates toward zero,
  // remainder takes the dividend's sign. Working on magnitudes also makes
  // 0x80000000 / -1 fall out as 0x80000000 with remainder 0.
  // Returns {remainder, quotient}; a zero divisor yields zero (never committed).
  function automatic logic [63:0] div32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    a_mag = a_neg ? neg32(a) : a;
    b_mag = b_neg ? neg32(b) : b;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? neg32(q_mag) : q_mag;
    rem  = a_neg ? neg32(r_mag) : r_mag;
    return {rem, quot};
  endfunction

  // Result that will be committed on the final RUN edge for the latched op.
  always_comb begin
    res_hi_s    = hi_r;
    res_lo_s    = lo_r;
    signed_op_s = (op_r == OP_MULT) || (op_r == OP_MADD) || (op_r == OP_DIV);
    prod_s      = mul64(a_r, b_r, signed_op_s);
    div_s       = div32(a_r, b_r, signed_op_s);
    case (op_r)
      OP_MULT, OP_MULTU: begin
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_r != 32'd0) begin
          res_hi_s = div_s[63:32];
          res_lo_s = div_s[31:0];
        end else begin
          res_hi_s = hi_r;
          res_lo_s = lo_r;
        end
      end
`ifdef MULT_DIV_MADD_EN
      OP_MADD, OP_MADDU: begin
        {res_hi_s, res_lo_s} = {hi_r, lo_r} + prod_s;
      end
`endif
      default: begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
      end
    endcase
  end

  // Control FSM: accepts requests in IDLE, counts down in RUN, commits HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      op_r    <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (md.start) begin
            case (md.md_op)
`ifdef MULT_DIV_MADD_EN
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
`else
              OP_MULT, OP_MULTU: begin
`endif
                op_r    <= md.md_op;
                a_r     <= md.A;
                b_r     <= md.B;
                cnt_r   <= MULT_CYCLES;
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_r    <= md.md_op;
                a_r     <= md.A;
                b_r     <= md.B;
                cnt_r   <= DIV_CYCLES;
                state_r <= ST_RUN;
                busy_r  <= 1'b1;
              end
              OP_MTHI: begin
                hi_r <= md.A;
              end
              OP_MTLO: begin
                lo_r <= md.A;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Requests arriving while busy are dropped without effect.
          if (cnt_r == 4'd1) begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            cnt_r   <= 4'd0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy      = busy_r;
  assign md.stall_req = md.start | busy_r;
  assign md.HI        = hi_r;
  assign md.LO        = lo_r;
  assign md.md_out    = md.rd_sel ? hi_r : lo_r;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, E-stage pulse requesting the operation on md_op.
REQ-004 SHALL have port md_op, input, 4, operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; 9-15 reserved.
REQ-005 SHALL have port A, input, 32, forwarded rs operand.
REQ-006 SHALL have port B, input, 32, forwarded rt operand.
REQ-007 SHALL have port rd_sel, input, 1, read select: 0 LO, 1 HI.
REQ-008 SHALL have port busy, output, 1, operation in flight; consumed by hazard unit to stall MDU-class instructions in D.
REQ-009 SHALL have port stall_req, output, 1, start OR busy, for hazard units needing start-cycle coverage.
REQ-010 SHALL have port HI, output, 32, architectural HI register.
REQ-011 SHALL have port LO, output, 32, architectural LO register.
REQ-012 SHALL have port md_out, output, 32, HI when rd_sel=1 else LO (MFHI/MFLO data, combinational).

Function
REQ-013 SHALL implement FSM with states IDLE and RUN plus 4-bit down-counter cnt.
REQ-014 SHALL, in IDLE with start=1 and md_op in {1,2,7,8}, latch operands and op, load cnt=5, enter RUN.
REQ-015 SHALL, in IDLE with start=1 and md_op in {3,4}, latch operands and op, load cnt=10, enter RUN.
REQ-016 SHALL assert busy exactly while in RUN: first busy cycle is the one after the start edge; busy high for 5 (mult) or 10 (div) cycles.
REQ-017 SHALL decrement cnt each RUN cycle; when cnt reaches 1, commit result to HI/LO on that edge and return to IDLE, so HI/LO and busy=0 appear together.
REQ-018 SHALL compute MULT as signed 32x32 -> 64 product, HI=[63:32], LO=[31:0]; MULTU unsigned.
REQ-019 SHALL compute DIV as signed: LO=quotient truncated toward zero, HI=remainder with sign of dividend; DIVU unsigned.
REQ-020 SHALL, for DIV/DIVU with B=0, run full 10 cycles and leave HI and LO unchanged.
REQ-021 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-022 SHALL, on start with md_op=5 (MTHI) or 6 (MTLO) in IDLE, write A into HI or LO on that edge; busy stays 0.
REQ-023 SHALL ignore start while busy=1 (hazard unit guarantees none occur; no state change if it does).
REQ-024 SHALL treat md_op 0 and 9-15 as no-op with no state change.
REQ-025 SHALL hold HI/LO at their pre-operation values throughout RUN; md_out reflects those values.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force state=IDLE, cnt=0, busy=0, HI=0, LO=0 and clear latched operands.
REQ-027 SHALL abort any in-flight operation on reset assertion with no result committed.
REQ-028 SHALL ignore start on the first edge after reset_n deassertion only if reset_n is still low at that edge.

Configuration
REQ-029 SHALL, with macro MULT_DIV_MADD_EN defined, implement MADD/MADDU as {HI,LO} += signed/unsigned A*B (64-bit wrap), 5-cycle latency like MULT.
REQ-030 SHALL, without MULT_DIV_MADD_EN, treat md_op 7 and 8 as no-op: no busy, no HI/LO change.

Verification
REQ-031 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 SHALL cover: DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=1.
REQ-033 SHALL cover: HI=0x11, LO=0x22 preset via MTHI/MTLO, then DIV B=0 -> after 10 cycles HI=0x11, LO=0x22, busy=0.
REQ-034 SHALL cover: reset_n pulled low in cycle 3 of DIVU -> busy=0, HI=LO=0 immediately; new MULTU 4*5 after release -> LO=20.
REQ-035 SHALL cover: start with MULT at busy=1 during a DIV -> ignored; DIV result only, total busy 10 cycles.
REQ-036 SHALL cover: with MULT_DIV_MADD_EN, HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0; without macro -> unchanged, busy never high.
